// File: rtl/gray_ptr_rd_ctrl.sv
// Read-side pointer controller for a dual-clock buffer: synchronizes the writer's
// Gray pointer, tracks the local read pointer and reports empty/level/errors.
module gray_ptr_rd_ctrl #(
  parameter int AW          = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW:0]   wr_ptr_gray,
  input  logic          pop,
  output logic          pop_ok,
  output logic [AW-1:0] rd_addr,
  output logic [AW:0]   rd_ptr_gray,
  output logic          empty,
  output logic [AW:0]   level,
  output logic          underflow,
  output logic          ptr_err
);

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] ONE   = {{AW{1'b0}}, 1'b1};

  function automatic logic [AW:0] bin2gray(input logic [AW:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
    logic [AW:0] b;
    b[AW] = g[AW];
    for (int i = AW - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [AW:0] sync_q [SYNC_STAGES];
  logic [AW:0] rd_bin;
  logic [AW:0] rd_bin_n;
  logic [AW:0] ws_n;
  logic [AW:0] wbin_n;
  logic [AW:0] lvl_n;
  logic [AW:0] hop;
  logic        do_pop;
  logic        overrun;
  logic        multi_hop;

  // Plain flop chain: no logic between stages so each stage sees a clean Gray code.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= wr_ptr_gray;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  // Handshake: pop is a request; pop_ok = pop & !empty marks the accepted cycle,
  // in which the consumer reads the entry at rd_addr. A pop while empty is dropped.
  assign do_pop   = pop & ~empty;
  assign pop_ok   = do_pop;
  assign rd_bin_n = rd_bin + (do_pop ? ONE : '0);

  // Status is computed from the value entering the last stage, so empty/level
  // and the last stage always describe the same writer sample.
  assign ws_n      = sync_q[SYNC_STAGES-2];
  assign wbin_n    = gray2bin(ws_n);
  assign lvl_n     = wbin_n - rd_bin_n;
  assign overrun   = lvl_n > DEPTH;
  assign hop       = ws_n ^ sync_q[SYNC_STAGES-1];
  assign multi_hop = (hop & (hop - ONE)) != '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_bin      <= '0;
      rd_ptr_gray <= '0;
      empty       <= 1'b1;
      level       <= '0;
      underflow   <= 1'b0;
      ptr_err     <= 1'b0;
    end else begin
      rd_bin      <= rd_bin_n;
      rd_ptr_gray <= bin2gray(rd_bin_n);
      empty       <= (bin2gray(rd_bin_n) == ws_n);
      level       <= lvl_n;
      if (pop && empty) begin
        underflow <= 1'b1;
      end
      if (overrun || multi_hop) begin
        ptr_err <= 1'b1;
      end
    end
  end

  assign rd_addr = rd_bin[AW-1:0];

endmodule

// File: tb/tb_gray_ptr_rd_ctrl.sv
// Randomized scoreboard bench for gray_ptr_rd_ctrl (AW=3, SYNC_STAGES=2) against a
// count-based reference model of the reader/writer occupancy.
module tb_gray_ptr_rd_ctrl;
  localparam int AW    = 3;
  localparam int SYNC  = 2;
  localparam int MOD   = 16;
  localparam int DEPTH = 8;
  localparam int EW    = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          pop;
  logic          pop_ok;
  logic [AW:0]   wr_ptr_gray;
  logic [AW-1:0] rd_addr;
  logic [AW:0]   rd_ptr_gray;
  logic          empty;
  logic [AW:0]   level;
  logic          underflow;
  logic          ptr_err;

  gray_ptr_rd_ctrl #(.AW(AW), .SYNC_STAGES(SYNC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_ptr_gray (wr_ptr_gray),
    .pop         (pop),
    .pop_ok      (pop_ok),
    .rd_addr     (rd_addr),
    .rd_ptr_gray (rd_ptr_gray),
    .empty       (empty),
    .level       (level),
    .underflow   (underflow),
    .ptr_err     (ptr_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model: true counts of entries written and read since reset
  int  m_rd;
  int  hist[$];
  int  m_ws;
  bit  m_empty;
  int  m_level;
  bit  m_under;
  bit  m_err;
  int  wcnt;
  int  n_cmp;
  int  n_bad;
  logic [EW-1:0] exp_q[$];

  function automatic int b2g(input int b);
    return (b ^ (b >> 1)) % MOD;
  endfunction

  function automatic int g2b(input int g);
    int b;
    b = g;
    for (int s = 1; s <= AW; s++) b = b ^ (g >> s);
    return b % MOD;
  endfunction

  task automatic model_reset();
    m_rd = 0;
    hist.delete();
    for (int i = 0; i < SYNC - 1; i++) hist.push_back(0);
    m_ws    = 0;
    m_empty = 1'b1;
    m_level = 0;
    m_under = 1'b0;
    m_err   = 1'b0;
  endtask

  // driver: applies one cycle of inputs and queues the expected response
  task automatic cycle(input bit r, input bit p, input int wg);
    logic [EW-1:0] e;
    int ws;
    int lvl;
    int rq;
    bit pok;
    @(negedge clk);
    rst_n       = r;
    pop         = p;
    wr_ptr_gray = wg[AW:0];
    pok = p && !m_empty;
    if (!r) begin
      model_reset();
    end else begin
      if (pok) m_rd++;
      hist.push_back(wg);
      if (hist.size() > SYNC) void'(hist.pop_front());
      ws  = hist[hist.size() - SYNC];
      lvl = (g2b(ws) - (m_rd % MOD) + MOD) % MOD;
      if (p && m_empty) m_under = 1'b1;
      if (lvl > DEPTH || $countones(ws ^ m_ws) > 1) m_err = 1'b1;
      m_ws    = ws;
      m_empty = (lvl == 0);
      m_level = lvl;
    end
    rq = m_rd % MOD;
    e = {pok, 3'(rq % DEPTH), 4'(b2g(rq)), m_empty, 4'(m_level), m_under, m_err};
    exp_q.push_back(e);
  endtask

  task automatic step(input bit p);
    cycle(1'b1, p, b2g(wcnt % MOD));
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 0);
    wcnt = 0;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard monitor: pop_ok just before the edge, registered state just after
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      #4;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("pop_ok", int'(pop_ok), int'(e[14]));
        @(posedge clk);
        #1;
        chk("rd_addr", int'(rd_addr), int'(e[13:11]));
        chk("rd_ptr_gray", int'(rd_ptr_gray), int'(e[10:7]));
        chk("empty", int'(empty), int'(e[6]));
        chk("level", int'(level), int'(e[5:2]));
        chk("underflow", int'(underflow), int'(e[1]));
        chk("ptr_err", int'(ptr_err), int'(e[0]));
      end
    end
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    wcnt  = 0;
    model_reset();
    rst_n       = 1'b0;
    pop         = 1'b0;
    wr_ptr_gray = '0;
    repeat (2) @(negedge clk);

    // reset hold and release
    do_reset(2);
    repeat (2) step(1'b0);

    // single write: visible after two edges, then one pop
    wcnt = 1;
    repeat (3) step(1'b0);
    step(1'b1);
    repeat (2) step(1'b0);

    // fill to 8 one increment at a time, then 8 back-to-back pops
    do_reset(1);
    for (int i = 0; i < DEPTH; i++) begin
      wcnt++;
      step(1'b0);
    end
    repeat (3) step(1'b0);
    repeat (DEPTH) step(1'b1);
    repeat (2) step(1'b0);

    // random concurrent traffic over several pointer wraps
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 1) == 1 && (wcnt - m_rd) < DEPTH) wcnt++;
      step(1'($urandom_range(0, 1)));
    end

    // drain, pop while empty, then refill: underflow must stay set
    repeat (14) step(1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      wcnt++;
      step(1'b0);
    end
    repeat (3) step(1'b0);
    step(1'b1);

    // reset mid-stream
    cycle(1'b0, 1'b1, b2g(wcnt % MOD));
    wcnt = 0;
    repeat (2) step(1'b0);

    // illegal two-bit Gray hop 0 -> 3
    repeat (3) cycle(1'b1, 1'b0, 3);
    do_reset(1);
    repeat (2) step(1'b0);

    // writer overruns the reader: binary 9 with nothing read
    for (int i = 0; i < DEPTH + 1; i++) begin
      wcnt++;
      step(1'b0);
    end
    repeat (3) step(1'b0);

    for (int i = 0; i < 8 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
